// File: rtl/frame_sample_streamer.sv
// Snapshots a 256-sample frame and plays it out over a valid/ready port at a fixed tick rate,
// with one-shot or looped playback, abort, and saturating overrun counting.
module frame_sample_streamer #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_flg,
    input  logic [7:0]       inputQuantSig [0:255],
    input  logic             start_stream,
    input  logic             stop_stream,
    input  logic             loop_en,
    input  logic             sample_ready,
    output logic [7:0]       sample_out,
    output logic             sample_valid,
    output logic [7:0]       sample_idx,
    output logic             busy,
    output logic             done_flg,
    output logic [7:0]       overrun_cnt
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StStream = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       idx_q;
    logic [7:0]       sample_out_q;
    logic [7:0]       sample_idx_q;
    logic             sample_valid_q;
    logic [7:0]       overrun_q;
    logic [7:0]       frame_q [0:255];

    logic tick;
    logic hs;
    logic finish;
    logic reload;
    logic lost;

    always_comb begin
        tick   = (state_q == StStream) && (cnt_q == '0);
        hs     = sample_valid_q && sample_ready;
        finish = hs && (sample_idx_q == 8'd255) && !loop_en;
        // A tick may refill the slot only if it is empty or being emptied this cycle.
        reload = tick && (!sample_valid_q || hs) && !finish;
        lost   = tick && sample_valid_q && !hs;
    end

    // Frame buffer carries no reset; its contents only matter after a LOAD.
    always_ff @(posedge clk) begin
        if (state_q == StLoad) begin
            frame_q <= inputQuantSig;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            idx_q          <= '0;
            sample_out_q   <= '0;
            sample_idx_q   <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_stream && rdy_flg && !stop_stream) begin
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (stop_stream) begin
                        state_q        <= StIdle;
                        sample_valid_q <= 1'b0;
                    end else begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (stop_stream) begin
                        state_q        <= StIdle;
                        sample_valid_q <= 1'b0;
                    end else begin
                        cnt_q <= tick ? CNT_W'(DIV - 1) : cnt_q - CNT_W'(1);
                        if (reload) begin
                            sample_out_q   <= frame_q[idx_q];
                            sample_idx_q   <= idx_q;
                            sample_valid_q <= 1'b1;
                            idx_q          <= idx_q + 8'd1;
                        end else if (hs) begin
                            sample_valid_q <= 1'b0;
                        end
                        if (lost && overrun_q != 8'hff) begin
                            overrun_q <= overrun_q + 8'd1;
                        end
                        if (finish) begin
                            state_q <= StDone;
                        end
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    sample_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_idx   = sample_idx_q;
    assign sample_valid = sample_valid_q;
    assign overrun_cnt  = overrun_q;
    assign busy         = (state_q == StLoad) || (state_q == StStream);
    assign done_flg     = (state_q == StDone);

endmodule

// File: tb/tb_frame_sample_streamer.sv
// Directed bench for frame_sample_streamer: a DIV=4 and a DIV=1 instance share all inputs.
module tb_frame_sample_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy_flg;
    logic [7:0] frame [0:255];
    logic       start_stream;
    logic       stop_stream;
    logic       loop_en;
    logic       sample_ready;

    logic [7:0] o4_out, o4_idx, o4_ovr, o1_out, o1_idx, o1_ovr;
    logic       o4_valid, o4_busy, o4_done, o1_valid, o1_busy, o1_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    frame_sample_streamer #(.DIV(4), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .rdy_flg(rdy_flg), .inputQuantSig(frame),
        .start_stream(start_stream), .stop_stream(stop_stream), .loop_en(loop_en),
        .sample_ready(sample_ready), .sample_out(o4_out), .sample_valid(o4_valid),
        .sample_idx(o4_idx), .busy(o4_busy), .done_flg(o4_done), .overrun_cnt(o4_ovr)
    );

    frame_sample_streamer #(.DIV(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .rdy_flg(rdy_flg), .inputQuantSig(frame),
        .start_stream(start_stream), .stop_stream(stop_stream), .loop_en(loop_en),
        .sample_ready(sample_ready), .sample_out(o1_out), .sample_valid(o1_valid),
        .sample_idx(o1_idx), .busy(o1_busy), .done_flg(o1_done), .overrun_cnt(o1_ovr)
    );

    typedef struct {
        logic       start;
        logic       ready;
        logic       ev;
        logic [7:0] eidx;
        logic [7:0] eout;
        logic       ebusy;
        logic       edone;
    } vec_t;

    vec_t tbl [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic ramp(input int offset);
        for (int i = 0; i < 256; i++) frame[i] = 8'(i + offset);
    endtask

    task automatic pulse_start();
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
    endtask

    // Steps until the DIV=4 instance shows valid; n = steps taken, -1 on timeout.
    task automatic wait_v(input int limit, output int n, output bit saw_done);
        n = -1;
        saw_done = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (o4_done) saw_done = 1'b1;
            if (o4_valid) begin
                n = k;
                break;
            end
        end
        if (n < 0) chk("wait_valid_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        bit d;
        rst = 1'b1; rdy_flg = 1'b1; start_stream = 1'b0; stop_stream = 1'b0;
        loop_en = 1'b0; sample_ready = 1'b1;
        ramp(0);
        do_reset();
        chk("rst_valid", o4_valid, 0);
        chk("rst_idx", o4_idx, 0);
        chk("rst_out", o4_out, 0);
        chk("rst_busy", o4_busy, 0);
        chk("rst_done", o4_done, 0);
        chk("rst_ovr", o4_ovr, 0);

        // Single pass, DIV=4, ramp frame, ready high.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 8'd2, 8'd2, 1'b1, 1'b0};
        for (int r = 0; r < 11; r++) begin
            start_stream = tbl[r].start;
            sample_ready = tbl[r].ready;
            step();
            chk($sformatf("tbl%0d_valid", r), o4_valid, tbl[r].ev);
            chk($sformatf("tbl%0d_busy", r), o4_busy, tbl[r].ebusy);
            chk($sformatf("tbl%0d_done", r), o4_done, tbl[r].edone);
            if (tbl[r].ev) begin
                chk($sformatf("tbl%0d_idx", r), o4_idx, tbl[r].eidx);
                chk($sformatf("tbl%0d_out", r), o4_out, tbl[r].eout);
            end
        end
        start_stream = 1'b0;
        for (int i = 3; i < 256; i++) begin
            wait_v(8, n, d);
            chk($sformatf("a_gap%0d", i), n, 4);
            chk($sformatf("a_idx%0d", i), o4_idx, i);
            chk($sformatf("a_out%0d", i), o4_out, i);
        end
        step();
        chk("a_done", o4_done, 1);
        chk("a_done_busy", o4_busy, 0);
        chk("a_done_valid", o4_valid, 0);
        step();
        chk("a_done_once", o4_done, 0);
        chk("a_idle_busy", o4_busy, 0);
        chk("a_ovr", o4_ovr, 0);

        // DIV=1 back-to-back, descending frame.
        do_reset();
        for (int i = 0; i < 256; i++) frame[i] = 8'(255 - i);
        pulse_start();
        step();
        for (int i = 0; i < 256; i++) begin
            step();
            chk($sformatf("b_valid%0d", i), o1_valid, 1);
            chk($sformatf("b_idx%0d", i), o1_idx, i);
            chk($sformatf("b_out%0d", i), o1_out, 255 - i);
        end
        step();
        chk("b_done", o1_done, 1);
        chk("b_end_valid", o1_valid, 0);
        chk("b_ovr", o1_ovr, 0);

        // Stall at idx 5 for 10 cycles: ticks at +4 and +8 are lost.
        do_reset();
        ramp(0);
        pulse_start();
        for (int s = 0; s < 6; s++) begin
            wait_v(8, n, d);
            if (o4_idx == 8'd5) break;
        end
        chk("c_idx5", o4_idx, 5);
        sample_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("c_hold_valid%0d", k), o4_valid, 1);
            chk($sformatf("c_hold_out%0d", k), o4_out, 5);
        end
        chk("c_ovr2", o4_ovr, 2);
        sample_ready = 1'b1;
        step();
        chk("c_release_valid", o4_valid, 0);
        step();
        chk("c_next_valid", o4_valid, 1);
        chk("c_next_idx", o4_idx, 6);
        chk("c_next_out", o4_out, 6);
        stop_stream = 1'b1;
        step();
        stop_stream = 1'b0;
        chk("c_stop_busy", o4_busy, 0);
        chk("c_stop_valid", o4_valid, 0);
        chk("c_stop_done", o4_done, 0);
        step();
        chk("c_stop_nodone", o4_done, 0);
        chk("c_ovr_kept", o4_ovr, 2);
        pulse_start();
        chk("c_load_busy", o4_busy, 1);
        chk("c_load_ovr", o4_ovr, 2);
        stop_stream = 1'b1;
        step();
        stop_stream = 1'b0;
        chk("c_stop_load_busy", o4_busy, 0);
        chk("c_stop_load_valid", o4_valid, 0);
        step();
        chk("c_stop_load_done", o4_done, 0);

        // Loop playback wraps 255 -> 0 without done, then abort at idx 20.
        do_reset();
        ramp(0);
        loop_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            wait_v(8, n, d);
            chk($sformatf("d_idx%0d", i), o4_idx, i);
        end
        wait_v(8, n, d);
        chk("d_wrap_idx", o4_idx, 0);
        chk("d_wrap_nodone", d, 0);
        for (int i = 1; i <= 20; i++) wait_v(8, n, d);
        chk("d_idx20", o4_idx, 20);
        stop_stream = 1'b1;
        step();
        stop_stream = 1'b0;
        chk("d_stop_valid", o4_valid, 0);
        chk("d_stop_busy", o4_busy, 0);
        chk("d_stop_done", o4_done, 0);
        step();
        chk("d_after_done", o4_done, 0);
        chk("d_after_busy", o4_busy, 0);
        loop_en = 1'b0;

        // Frame changes after LOAD must not reach the playing snapshot.
        do_reset();
        ramp(0);
        pulse_start();
        step();
        for (int i = 0; i < 256; i++) frame[i] = 8'haa;
        for (int i = 0; i < 8; i++) begin
            wait_v(8, n, d);
            chk($sformatf("e_snap%0d", i), o4_out, i);
        end
        stop_stream = 1'b1;
        step();
        stop_stream = 1'b0;
        rdy_flg = 1'b0;
        pulse_start();
        chk("e_nordy_busy", o4_busy, 0);
        step();
        chk("e_nordy_busy2", o4_busy, 0);
        chk("e_nordy_valid", o4_valid, 0);
        rdy_flg = 1'b1;

        // Reset mid-stream with valid high and ready low.
        do_reset();
        ramp(1);
        sample_ready = 1'b0;
        pulse_start();
        wait_v(8, n, d);
        for (int k = 0; k < 5; k++) step();
        chk("f_pre_valid", o4_valid, 1);
        chk("f_pre_out", o4_out, 1);
        chk("f_pre_ovr", o4_ovr, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("f_rst_valid", o4_valid, 0);
        chk("f_rst_out", o4_out, 0);
        chk("f_rst_idx", o4_idx, 0);
        chk("f_rst_busy", o4_busy, 0);
        chk("f_rst_done", o4_done, 0);
        chk("f_rst_ovr", o4_ovr, 0);
        sample_ready = 1'b1;
        start_stream = 1'b1;
        stop_stream  = 1'b1;
        step();
        start_stream = 1'b0;
        stop_stream  = 1'b0;
        chk("f_both_busy", o4_busy, 0);
        step();
        chk("f_both_busy2", o4_busy, 0);
        chk("f_both_valid", o4_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
